// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port integer register file.
// Provides default geometry, the register-index type and the zero-register index.
package rf_pkg;

  localparam int unsigned XLEN_DEF  = 32;
  localparam int unsigned NREGS_DEF = 32;
  localparam int unsigned AW_DEF    = $clog2(NREGS_DEF);

  // Register index at the default geometry
  typedef logic [AW_DEF-1:0] reg_idx_t;

  // Architectural x0: reads as zero, never written, never pending
  localparam int unsigned ZERO_REG = 0;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending (scoreboard) bits for the register file.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   iss_en, iss_addr  issue strobe and destination; marks the register pending
//   flush             clears every pending bit (issue ignored that cycle)
//   wr_en, wr_addr    writeback ports; an enabled write clears its target's bit
//   busy_vec          registered scoreboard, bit i = register i pending
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int unsigned NREGS = NREGS_DEF,
  parameter  int unsigned NWR   = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_en,
  input  logic [AW-1:0]     iss_addr,
  input  logic              flush,
  input  logic [NWR-1:0]    wr_en,
  input  logic [NWR*AW-1:0] wr_addr,
  output logic [NREGS-1:0]  busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Priority: flush > issue > writeback clear > hold
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j]) begin
          busy_d[wr_addr[j*AW +: AW]] = 1'b0;
        end
      end
      // Applied after the clears so a new producer owns the register
      if (iss_en) begin
        busy_d[iss_addr] = 1'b1;
      end
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-port integer register file with scoreboard.
// NRD asynchronous read ports, NWR synchronous write ports, x0 hardwired to zero.
// Optional feature macro: RF_BYPASS_EN -- same-cycle write-to-read forwarding.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   rd_addr / rd_data    read port k at [k*AW +: AW] / [k*XLEN +: XLEN]
//   rd_busy              pending bit of the register addressed by read port k
//   wr_en/addr/data      write ports; highest-index port wins on conflict
//   iss_en, iss_addr     issue strobe marking a destination pending
//   flush                clears all pending bits
//   busy_vec             full scoreboard
module reg_file_mp
  import rf_pkg::*;
#(
  parameter  int unsigned XLEN  = XLEN_DEF,
  parameter  int unsigned NREGS = NREGS_DEF,
  parameter  int unsigned NRD   = 2,
  parameter  int unsigned NWR   = 1,
  localparam int unsigned AW    = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                iss_en,
  input  logic [AW-1:0]       iss_addr,
  input  logic                flush,
  output logic [NREGS-1:0]    busy_vec
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [AW-1:0]   rd_idx [NRD];

  // Storage next-state: ascending port order makes the highest index win
  always_comb begin
    regs_d = regs_q;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && (wr_addr[j*AW +: AW] != AW'(ZERO_REG))) begin
        regs_d[wr_addr[j*AW +: AW]] = wr_data[j*XLEN +: XLEN];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NWR   (NWR)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy_vec (busy_vec)
  );

  // Unpack read addresses per port
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      rd_idx[k] = rd_addr[k*AW +: AW];
    end
  end

  // Read mux with x0 forced to zero and optional write forwarding
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int k = 0; k < NRD; k++) begin
      if (rd_idx[k] != AW'(ZERO_REG)) begin
        rd_data[k*XLEN +: XLEN] = regs_q[rd_idx[k]];
        rd_busy[k]              = busy_vec[rd_idx[k]];
`ifdef RF_BYPASS_EN
        // Reset must win, so forwarding is suppressed while rst is held
        for (int j = 0; j < NWR; j++) begin
          if (!rst && wr_en[j] && (wr_addr[j*AW +: AW] == rd_idx[k])) begin
            rd_data[k*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
            rd_busy[k]              = 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_reg_file_mp.sv
module tb_reg_file_mp;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned NRD   = 2;
  localparam int unsigned NWR   = 2;
  localparam int unsigned AW    = 5;

  logic                clk;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NWR-1:0]      wr_en;
  logic [NWR*AW-1:0]   wr_addr;
  logic [NWR*XLEN-1:0] wr_data;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic                flush;
  logic [NREGS-1:0]    busy_vec;

  int total = 0;
  int bad   = 0;

  // Reference model: architectural register values and pending set
  logic [XLEN-1:0]  m_reg [NREGS];
  logic [NREGS-1:0] m_busy;

  reg_file_mp #(
    .XLEN  (XLEN),
    .NREGS (NREGS),
    .NRD   (NRD),
    .NWR   (NWR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .flush    (flush),
    .busy_vec (busy_vec)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] waddr(input int j);
    return wr_addr[j*AW +: AW];
  endfunction

  function automatic logic [XLEN-1:0] wdat(input int j);
    return wr_data[j*XLEN +: XLEN];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NREGS; i++) m_reg[i] = '0;
    m_busy = '0;
  endtask

  // Architectural effect of one rising edge with the current inputs
  task automatic model_clock();
    if (rst) begin
      model_reset();
      return;
    end
    for (int j = 0; j < NWR; j++)
      if (wr_en[j] && waddr(j) != 0) m_reg[waddr(j)] = wdat(j);
    if (flush) begin
      m_busy = '0;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (wr_en[j]) m_busy[waddr(j)] = 1'b0;
      if (iss_en && iss_addr != 0) m_busy[iss_addr] = 1'b1;
    end
  endtask

  // Compare every output against what the model says it must be now
  task automatic check_all();
    for (int k = 0; k < NRD; k++) begin
      logic [AW-1:0]   a;
      logic [XLEN-1:0] ed;
      logic            eb;
      a  = rd_addr[k*AW +: AW];
      ed = '0;
      eb = 1'b0;
      if (!rst && a != 0) begin
        ed = m_reg[a];
        eb = m_busy[a];
`ifdef RF_BYPASS_EN
        for (int j = 0; j < NWR; j++)
          if (wr_en[j] && waddr(j) == a) begin
            ed = wdat(j);
            eb = 1'b0;
          end
`endif
      end
      chk($sformatf("rd_data[%0d] addr=%0d", k, a), 64'(rd_data[k*XLEN +: XLEN]), 64'(ed));
      chk($sformatf("rd_busy[%0d] addr=%0d", k, a), 64'(rd_busy[k]), 64'(eb));
    end
    chk("busy_vec", 64'(busy_vec), 64'(m_busy));
  endtask

  // Called at a falling edge with inputs applied
  task automatic tick();
    #1 check_all();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en  = '0;
    iss_en = 1'b0;
    flush  = 1'b0;
  endtask

  task automatic rand_inputs();
    logic [AW-1:0] a0, a1;
    bit narrow;
    narrow  = ($urandom_range(0, 1) == 1);
    a0      = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS - 1));
    a1      = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS - 1));
    wr_en   = NWR'($urandom_range(0, 3));
    wr_addr = {a1, a0};
    wr_data = {$urandom, $urandom};
    iss_en  = ($urandom_range(0, 2) == 0);
    iss_addr = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, NREGS - 1));
    flush   = ($urandom_range(0, 19) == 0);
    rd_addr = {AW'($urandom_range(0, NREGS - 1)), AW'($urandom_range(0, NREGS - 1))};
    if ($urandom_range(0, 2) == 0) rd_addr[AW-1:0] = a0;
    if ($urandom_range(0, 2) == 0) rd_addr[2*AW-1:AW] = a1;
  endtask

  initial begin
    logic [XLEN-1:0] exp_pre;
    rst = 1'b1;
    idle();
    rd_addr  = '0;
    wr_addr  = '0;
    wr_data  = '0;
    iss_addr = '0;
    model_reset();
    #2;
    check_all();
    chk("reset_busy_vec", 64'(busy_vec), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    // x0 protection: write and issue to register 0
    wr_en = 2'b01; wr_addr = {5'd0, 5'd0}; wr_data = {32'h0, 32'hDEADBEEF};
    tick();
    idle(); rd_addr = {5'd0, 5'd0};
    #1 chk("x0_read", 64'(rd_data[31:0]), 64'h0);
    iss_en = 1'b1; iss_addr = 5'd0;
    tick();
    idle();
    #1 chk("x0_busy", 64'(busy_vec[0]), 64'h0);

    // Two ports write register 5; port 1 must win
    wr_en = 2'b11; wr_addr = {5'd5, 5'd5}; wr_data = {32'h22222222, 32'h11111111};
    tick();
    idle(); rd_addr = {5'd0, 5'd5};
    #1 chk("wr_conflict", 64'(rd_data[31:0]), 64'h22222222);

    // Scoreboard set, clear, and issue beating writeback
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    idle(); rd_addr = {5'd7, 5'd5};
    #1 chk("iss7_vec", 64'(busy_vec[7]), 64'h1);
    chk("iss7_rd_busy", 64'(rd_busy[1]), 64'h1);
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'h00000077};
    tick();
    idle();
    #1 chk("wb7_clear", 64'(busy_vec[7]), 64'h0);
    iss_en = 1'b1; iss_addr = 5'd7;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'h0, 32'h00000078};
    tick();
    idle();
    #1 chk("iss_beats_wb", 64'(busy_vec[7]), 64'h1);

    // Flush with a concurrent issue and writeback
    iss_en = 1'b1; iss_addr = 5'd3; tick();
    iss_en = 1'b1; iss_addr = 5'd4; tick();
    iss_en = 1'b1; iss_addr = 5'd9; tick();
    idle();
    #1 chk("pend_3_4_7_9", 64'(busy_vec), 64'h00000298);
    flush = 1'b1; iss_en = 1'b1; iss_addr = 5'd10;
    wr_en = 2'b01; wr_addr = {5'd0, 5'd3}; wr_data = {32'h0, 32'hCAFEF00D};
    tick();
    idle(); rd_addr = {5'd0, 5'd3};
    #1 chk("flush_vec", 64'(busy_vec), 64'h0);
    chk("flush_wr_commit", 64'(rd_data[31:0]), 64'hCAFEF00D);

    // Same-cycle write and read of register 12
    wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'h0, 32'h12345678};
    tick();
    idle();
    wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'h0, 32'h00ABCDEF};
    rd_addr = {5'd0, 5'd12};
`ifdef RF_BYPASS_EN
    exp_pre = 32'h00ABCDEF;
`else
    exp_pre = 32'h12345678;
`endif
    #1 chk("bypass_pre_edge", 64'(rd_data[31:0]), 64'(exp_pre));
    tick();
    idle();
    #1 chk("bypass_post_edge", 64'(rd_data[31:0]), 64'h00ABCDEF);

    // Randomised traffic against the model
    repeat (3000) begin
      rand_inputs();
      tick();
    end

    // Asynchronous reset mid-run: outputs clear without a clock edge
    idle();
    #2 rst = 1'b1;
    model_reset();
    for (int a = 0; a < NREGS; a++) begin
      rd_addr = {AW'(NREGS - 1 - a), AW'(a)};
      #1 check_all();
      chk("rst_rd_zero", 64'(rd_data), 64'h0);
    end
    chk("rst_busy_vec", 64'(busy_vec), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    repeat (500) begin
      rand_inputs();
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port integer register file; the next generation of the core's GPR array.
- Provides NRD asynchronous read ports and NWR synchronous write ports.
- Register 0 is hardwired to zero.
- A per-register pending (scoreboard) bit is set on instruction issue and cleared on writeback, so the decode/hazard unit can stall. A trap flush clears all pending bits.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers (power of two, at least 2).
- NRD, 2, number of read ports.
- NWR, 1, number of write ports (1..4).
- AW, $clog2(NREGS), register address width (derived localparam, not user-set).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data, port k at [k*XLEN +: XLEN].
- rd_busy  out  NRD  pending bit of the register addressed by port k.
- wr_en  in  NWR  write enable per write port.
- wr_addr  in  NWR*AW  write addresses.
- wr_data  in  NWR*XLEN  write data.
- iss_en  in  1  issue strobe; marks iss_addr pending.
- iss_addr  in  AW  destination register of the issuing instruction.
- flush  in  1  trap/flush; clears all pending bits.
- busy_vec  out  NREGS  full scoreboard, bit i = register i pending.

Behaviour:
- Reset (async, rst=1):
  - All registers become 0 and all pending bits become 0.
  - Hence rd_data=0, rd_busy=0 and busy_vec=0 while reset is held.
  - Reset asserted mid-operation wins over every other input in that cycle.
- Reads:
  - Combinational from rd_addr; zero latency.
  - Address 0 always returns 0 and rd_busy=0.
- Writes:
  - On posedge clk, for each port j with wr_en[j]=1 and wr_addr[j]!=0, reg[wr_addr[j]] <= wr_data[j].
  - Writes to address 0 are discarded.
  - If two ports write the same register in one cycle, the highest-index port wins.
- Pending bits, priority per register i at posedge:
  1. flush=1: all bits cleared; iss_en is ignored that cycle.
  2. iss_en=1 and iss_addr==i (i!=0): bit set. Issue beats a same-cycle writeback to the same register, because the new producer owns it.
  3. Any enabled write port targets i: bit cleared.
  4. Otherwise the bit holds.
- Bit 0 is never set.
- flush does not block register writes in the same cycle; in-flight writebacks still commit.
- Read-after-write latency without the bypass feature: write at edge N is visible on rd_data after edge N; rd_busy drops after edge N.
- Out-of-range behaviour is impossible by construction: AW exactly covers NREGS.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined:
  - Each read port compares rd_addr against all enabled write ports in the same cycle, excluding address 0.
  - On a match, rd_data returns the highest-index matching wr_data and rd_busy returns 0 combinationally.
  - This yields same-cycle write-to-read forwarding, functionally equivalent to a write-first array.
- Undefined: reads return the stored array value only; forwarding is the pipeline's responsibility.

Decomposition:
- Shared package rf_pkg:
  - Default XLEN/NREGS constants.
  - Register-index typedef (AW-bit).
  - Constant for the zero register index.
- One natural sub-module: rf_scoreboard, holding the pending-bit array, its priority logic (flush/issue/clear) and the busy_vec output.
- Read muxing, the bypass network and the storage array stay in reg_file_mp.

Test Plan:
- Reset then read all addresses: pulse rst mid-simulation after writes -> every rd_data=0, busy_vec=0 immediately, without waiting for a clk edge.
- x0 protection: write 0xDEADBEEF to addr 0 -> rd_data for addr 0 stays 0. Then issue to addr 0 -> busy_vec[0] stays 0.
- Write-port conflict (NWR=2): port0 writes 0x11111111 and port1 writes 0x22222222 to addr 5 in the same cycle -> next cycle reg5 reads 0x22222222.
- Scoreboard: issue addr 7 -> busy_vec[7]=1 next cycle and rd_busy=1 when reading 7. Write addr 7 -> cleared next cycle. Issue 7 and write 7 in the same cycle -> remains 1.
- Flush: set pending on regs 3, 4 and 9, then assert flush together with iss_en on addr 10 -> busy_vec=0 next cycle. A write of 0xCAFEF00D to reg3 in that same cycle commits.
- Bypass (RF_BYPASS_EN defined): write 0x00ABCDEF to addr 12 while reading addr 12 in the same cycle -> rd_data=0x00ABCDEF before the edge. Without the macro, the old value is returned until after the edge.
